// File: rtl/candy_sram_ctrl_if.sv
// CPU-side request/response bundle for candy_sram_ctrl.
// The master is the memory pipeline stage; the slave is the controller.
interface candy_sram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/candy_sram_ctrl.sv
// Memory-stage front end for candy_sram: turns byte/half/word CPU requests into
// SRAM word accesses, using read-modify-write for sub-word stores.
module candy_sram_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    candy_sram_ctrl_if.slave  cpu,
    output logic              sram_re,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_raddr,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    input  logic              sram_rdata_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WRITE,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W+1:0]   addr_q;
    logic [1:0]          size_q;
    logic                we_q;
    logic                signed_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                req_bad;
    logic [31:0]         shifted;
    logic [31:0]         load_val;
    logic [31:0]         merged;
    logic [ADDR_W-1:0]   word_idx;

    assign word_idx = addr_q[ADDR_W+1:2];

    always_comb begin
        req_bad = (cpu.req_size == 2'b11)
                | ((cpu.req_size == 2'b01) & cpu.req_addr[0])
                | ((cpu.req_size == 2'b10) & (cpu.req_addr[1:0] != 2'b00))
                | (|cpu.req_addr[31:ADDR_W+2]);
    end

    // Load lane extraction and store lane merge both work on the word just returned.
    always_comb begin
        shifted  = sram_rdata >> {addr_q[1:0], 3'b000};
        load_val = shifted;
        merged   = sram_rdata;
        case (size_q)
            2'b00: begin
                load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_val = shifted;
                merged   = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu.req_valid) begin
                    if (req_bad)
                        state_d = RESP;
                    else if (cpu.req_we && cpu.req_size == 2'b10)
                        state_d = WRITE;
                    else
                        state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (sram_rdata_ready)
                    state_d = we_q ? WRITE : RESP;
                else if (cnt_q == CNT_LAST)
                    state_d = RESP;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is checked before the timeout so a late but valid return is never dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (cpu.req_valid) begin
                        addr_q   <= cpu.req_addr[ADDR_W+1:0];
                        size_q   <= cpu.req_size;
                        we_q     <= cpu.req_we;
                        signed_q <= cpu.req_signed;
                        wdata_q  <= cpu.req_wdata;
                        rdata_q  <= '0;
                        err_q    <= req_bad;
                        cnt_q    <= '0;
                    end
                end
                RD_ISSUE: cnt_q <= '0;
                RD_WAIT: begin
                    if (sram_rdata_ready) begin
                        if (we_q)
                            wdata_q <= merged;
                        else
                            rdata_q <= load_val;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs are Moore-decoded so the SRAM never sees a combinational path from the CPU.
    always_comb begin
        cpu.req_ready  = (state_q == IDLE);
        cpu.busy       = (state_q != IDLE);
        cpu.resp_valid = (state_q == RESP);
        cpu.resp_err   = (state_q == RESP) & err_q;
        cpu.resp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
        sram_re        = (state_q == RD_ISSUE) | (state_q == WRITE);
        sram_we        = (state_q == WRITE);
        sram_raddr     = (state_q == RD_ISSUE) ? word_idx : '0;
        sram_waddr     = (state_q == WRITE) ? word_idx : '0;
        sram_wdata     = (state_q == WRITE) ? wdata_q : 32'h0;
    end

endmodule

// File: doc/candy_sram_ctrl.md
Name: candy_sram_ctrl

Overview:
- Memory-stage front end that sits directly upstream of candy_sram.
- Converts one CPU load/store request (byte address, size, sign) into SRAM word accesses.
- Sub-word stores use a read-modify-write sequence. A single response is returned per request.
- The pipeline stalls on `busy` while an access is in flight.

Parameters:
- ADDR_W, 10, SRAM word-address width; SRAM depth is 2^ADDR_W 32-bit words.
- TIMEOUT, 15, max cycles spent in RD_WAIT before the access is aborted with an error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address, little-endian.
- req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_signed  input  1  sign-extend byte/half loads.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  qualifies resp_valid; misaligned, out-of-range, illegal size or timeout.
- busy  output  1  state != IDLE.
- sram_re  output  1  to SRAM read_enable.
- sram_we  output  1  to SRAM write_enable.
- sram_raddr  output  ADDR_W  to SRAM raddr.
- sram_waddr  output  ADDR_W  to SRAM waddr.
- sram_wdata  output  32  to SRAM wdata.
- sram_rdata  input  32  from SRAM rdata.
- sram_rdata_ready  input  1  from SRAM; one-cycle pulse, rdata valid in that cycle.

Behaviour:
- Reset: async assert (rst = 0) forces state IDLE and clears the captured request and timeout counter.
  - All outputs go to 0 except req_ready = 1.
  - Reset in mid-operation aborts the access: no write is issued and no response is produced.
- States: IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP. SRAM-side outputs are decoded from registered state and registered request only (Moore).
- IDLE: on req_valid at a rising edge, capture addr, size, we, signed and wdata. word_idx = addr[ADDR_W+1:2].
  - Error (illegal size, half at odd addr, word with addr[1:0] != 0, or addr[31:ADDR_W+2] != 0): go to RESP with err = 1. No SRAM activity.
  - Load or sub-word store: go to RD_ISSUE.
  - Word store: go to WRITE.
- RD_ISSUE (1 cycle): sram_re = 1, sram_we = 0, sram_raddr = word_idx. Go to RD_WAIT with the timeout counter cleared.
- RD_WAIT: sram_re = sram_we = 0. The counter increments each cycle.
  - On sram_rdata_ready = 1 with a load: extract lane(s) at addr[1:0], sign/zero-extend, go to RESP.
  - On sram_rdata_ready = 1 with a store: merge req_wdata into the read word at the byte lanes selected by addr[1:0] and size, register the result, go to WRITE.
  - Counter reaching TIMEOUT before ready: go to RESP with err = 1.
  - If ready and timeout fall in the same cycle, ready wins.
- WRITE (1 cycle): sram_we = 1 and sram_re = 1 (the SRAM commits a write only with both high). sram_waddr = word_idx, sram_wdata = merged or full word. Go to RESP.
- RESP (1 cycle): resp_valid = 1 with resp_rdata/resp_err. There is no backpressure. Go to IDLE.
- sram_re without sram_we is asserted only in RD_ISSUE. sram_we is asserted only in WRITE.
- Latency, counting from the accept edge: error 1 cycle to resp_valid; word store 2; load 3; sub-word store 4. Each assumes the SRAM returns ready one cycle after the read.
- Lane extraction: byte k = bits [8k+7:8k]; half at offset 2 = bits [31:16].

Test Plan:
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> WRITE shows sram_waddr = 4, we = re = 1; load resp_rdata = 0xDEADBEEF, err = 0, resp_valid 3 cycles after accept.
- Memory word 4 = 0x11223344; byte store 0xAA to addr 0x12 -> RD_ISSUE then WRITE with sram_wdata = 0x11AA3344; resp_valid 4 cycles after accept.
- Memory word 4 = 0x80FF7F01: signed byte load addr 0x11 -> 0x0000007F; signed byte load addr 0x12 -> 0xFFFFFFFF; unsigned half load addr 0x12 -> 0x000080FF; signed half load addr 0x12 -> 0xFFFF80FF.
- Half load addr 0x13, word load addr 0x06, size 11, addr 0x00001000 with ADDR_W = 10 -> each gives resp_err = 1 one cycle after accept; sram_re and sram_we stay 0 throughout.
- Hold sram_rdata_ready low -> resp_err = 1 after TIMEOUT cycles in RD_WAIT; no write issued even for a sub-word store.
- Assert rst low during RD_WAIT of a byte store -> outputs cleared immediately, req_ready = 1, no sram_we pulse, no resp_valid after release.
